// File: rtl/skylark_bnn_pkg.sv
// skylark_bnn_pkg: shared types and constants for the BNN execute path
package skylark_bnn_pkg;
   typedef enum logic [1:0] {BNN_RAW, BNN_THRESH, BNN_DOT, BNN_RSVD} bnn_func_t;
   typedef enum logic [1:0] {BNN_IDLE, BNN_COMPUTE, BNN_DONE} bnn_state_t;
   localparam logic [1:0] EXPATH_BNN = 2'b01;
endpackage

// File: rtl/popcount_slice.sv
// popcount_slice: combinational count of set bits in a W-bit slice
module popcount_slice #(
   parameter int W  = 8,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  i_bits,
   output logic [CW-1:0] o_count
);
   // ripple sum of single bits; synthesis folds this into an adder tree
   always_comb begin
      o_count = '0;
      for (int i = 0; i < W; i++) o_count = o_count + CW'(i_bits[i]);
   end
endmodule

// File: rtl/bnn_sequencer.sv
// bnn_sequencer: multi-cycle XNOR-popcount controller for the BNN execute path
module bnn_sequencer import skylark_bnn_pkg::*; #(
   parameter int XLEN    = 32,
   parameter int SLICE_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      bnn_func,
   input  logic [XLEN-1:0] OpA,
   input  logic [XLEN-1:0] OpB,
   input  logic [XLEN-1:0] Threshold,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] BNNResult
);
   localparam int NSLICE = XLEN / SLICE_W;
   localparam int CW     = $clog2(XLEN + 1);
   localparam int PW     = $clog2(SLICE_W + 1);
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   generate
      if (XLEN % SLICE_W != 0) begin : g_bad_slice
         $error("SLICE_W must divide XLEN");
      end
   endgenerate

   bnn_state_t      r_state, w_next_state;
   bnn_func_t       r_func;
   logic [XLEN-1:0] r_a, r_b, r_thr;
   logic [CW-1:0]   r_acc, w_acc_next;
   logic [IW-1:0]   r_idx;
   logic [PW-1:0]   w_cnt;
   logic [XLEN-1:0] w_pop_x, w_result;
   logic            w_launch, w_last, w_compute;

   popcount_slice #(.W(SLICE_W), .CW(PW)) u_pop (
      .i_bits  (~(r_a[SLICE_W*int'(r_idx) +: SLICE_W] ^ r_b[SLICE_W*int'(r_idx) +: SLICE_W])),
      .o_count (w_cnt)
   );

   // next state, outputs and the result that is committed on the last slice
   always_comb begin
      w_compute    = r_state == BNN_COMPUTE;
      w_launch     = (r_state == BNN_IDLE) && start && !flush;
      w_last       = r_idx == IW'(NSLICE - 1);
      w_acc_next   = r_acc + CW'(w_cnt);
      w_pop_x      = XLEN'(w_acc_next);
      w_result     = (r_func == BNN_THRESH) ? XLEN'(w_pop_x >= r_thr) :
                     (r_func == BNN_DOT)    ? (w_pop_x << 1) - XLEN'(XLEN) : w_pop_x;
      w_next_state = flush    ? BNN_IDLE :
                     w_launch ? BNN_COMPUTE :
                     w_compute ? (w_last ? BNN_DONE : BNN_COMPUTE) : BNN_IDLE;
      stall        = w_launch || (w_compute && !flush);
      busy         = r_state != BNN_IDLE;
      done         = r_state == BNN_DONE;
   end

   // state, operand latches, accumulator and result register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= BNN_IDLE;
         r_func    <= BNN_RAW;
         r_a       <= '0;
         r_b       <= '0;
         r_thr     <= '0;
         r_acc     <= '0;
         r_idx     <= '0;
         BNNResult <= '0;
      end else begin
         r_state <= w_next_state;
         if (flush) begin
            r_acc <= '0;
            r_idx <= '0;
         end else if (w_launch) begin
            r_a    <= OpA;
            r_b    <= OpB;
            r_thr  <= Threshold;
            r_func <= bnn_func_t'(bnn_func);
            r_acc  <= '0;
            r_idx  <= '0;
         end else if (w_compute) begin
            r_acc <= w_acc_next;
            r_idx <= r_idx + 1'b1;
            if (w_last) BNNResult <= w_result;
         end
      end
   end
endmodule

// File: tb/tb_bnn_sequencer.sv
// tb_bnn_sequencer: directed checks of the BNN sequencer
module tb_bnn_sequencer;
   logic        clk = 0;
   logic        reset = 1;
   logic        start = 0;
   logic [1:0]  bnn_func = 0;
   logic [31:0] OpA = 0, OpB = 0, Threshold = 0;
   logic        flush = 0;
   logic        stall, busy, done;
   logic [31:0] BNNResult;
   int          n_pass = 0, n_total = 0;

   bnn_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .bnn_func(bnn_func),
      .OpA(OpA), .OpB(OpB), .Threshold(Threshold), .flush(flush),
      .stall(stall), .busy(busy), .done(done), .BNNResult(BNNResult)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // drives one op from a negedge; returns at the negedge of the first COMPUTE cycle
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f, input logic [31:0] t);
      OpA = a; OpB = b; bnn_func = f; Threshold = t; start = 1;
      @(negedge clk);
      start = 0; OpA = $urandom; OpB = $urandom; Threshold = $urandom; bnn_func = 2'(f + 1);
   endtask

   // waits (bounded) for done; cyc is the cycle index counted from the start cycle, -1 on timeout
   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int n = 2; n < 20; n++) begin
         @(negedge clk);
         #1;
         if (done) begin
            cyc = n;
            return;
         end
      end
   endtask

   task automatic test_reset;
      #1;
      n_total++; if ({busy, stall, done} !== 3'b000) $display("FAIL reset_ctl: got %b want 000", {busy, stall, done}); else n_pass++;
      n_total++; if (BNNResult !== 32'd0) $display("FAIL reset_result: got %h want 0", BNNResult); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_raw_timing;
      OpA = '1; OpB = '1; bnn_func = 2'b00; start = 1;
      #1;
      n_total++; if (stall !== 1'b1 || done !== 1'b0) $display("FAIL raw_c0: stall=%b done=%b want 1 0", stall, done); else n_pass++;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         start = 0; OpA = 0;
         #1;
         n_total++; if (stall !== (c <= 4)) $display("FAIL raw_stall c%0d: got %b want %b", c, stall, c <= 4); else n_pass++;
         n_total++; if (done !== (c == 5)) $display("FAIL raw_done c%0d: got %b want %b", c, done, c == 5); else n_pass++;
         n_total++; if (busy !== (c <= 5)) $display("FAIL raw_busy c%0d: got %b want %b", c, busy, c <= 5); else n_pass++;
      end
      n_total++; if (BNNResult !== 32'd32) $display("FAIL raw_result: got %h want 20", BNNResult); else n_pass++;
   endtask

   task automatic test_funcs;
      logic [31:0] va [6] = '{32'hFFFFFFFF, 32'h0, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'hFFFF0000, 32'hF0F0F0F0};
      logic [31:0] vb [6] = '{32'h0, 32'h0, 32'hAAAA0000, 32'hAAAA0000, 32'h0, 32'h0F0F0F0F};
      logic [1:0]  vf [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10};
      logic [31:0] vt [6] = '{32'd0, 32'd0, 32'd16, 32'd25, 32'd0, 32'd0};
      logic [31:0] ve [6] = '{32'hFFFFFFE0, 32'd32, 32'd1, 32'd0, 32'd16, 32'hFFFFFFE0};
      int cyc;
      for (int i = 0; i < 6; i++) begin
         launch(va[i], vb[i], vf[i], vt[i]);
         wait_done(cyc);
         n_total++; if (cyc !== 5) $display("FAIL func%0d_latency: got %0d want 5", i, cyc); else n_pass++;
         n_total++; if (BNNResult !== ve[i]) $display("FAIL func%0d_result: got %h want %h", i, BNNResult, ve[i]); else n_pass++;
         @(negedge clk);
      end
   endtask

   task automatic test_flush;
      int seen = 0;
      int cyc;
      launch('1, '1, 2'b00, 0);
      wait_done(cyc);
      @(negedge clk);
      n_total++; if (BNNResult !== 32'd32) $display("FAIL flush_pre: got %h want 20", BNNResult); else n_pass++;
      launch(32'h0, 32'hFFFFFFFF, 2'b00, 0);
      @(negedge clk);
      flush = 1;
      #1;
      n_total++; if (stall !== 1'b0 || busy !== 1'b1) $display("FAIL flush_cycle: stall=%b busy=%b want 0 1", stall, busy); else n_pass++;
      @(negedge clk);
      flush = 0;
      #1;
      n_total++; if ({busy, stall, done} !== 3'b000) $display("FAIL flush_idle: got %b want 000", {busy, stall, done}); else n_pass++;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done) seen++;
      end
      n_total++; if (seen !== 0) $display("FAIL flush_nodone: got %0d pulses want 0", seen); else n_pass++;
      n_total++; if (BNNResult !== 32'd32) $display("FAIL flush_result: got %h want 20", BNNResult); else n_pass++;
   endtask

   task automatic test_async_reset;
      int cyc;
      launch('1, '1, 2'b00, 0);
      #2 reset = 1;
      #1;
      n_total++; if ({busy, stall, done} !== 3'b000) $display("FAIL areset_ctl: got %b want 000", {busy, stall, done}); else n_pass++;
      n_total++; if (BNNResult !== 32'd0) $display("FAIL areset_result: got %h want 0", BNNResult); else n_pass++;
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      launch(32'h0000FFFF, 32'h0, 2'b00, 0);
      wait_done(cyc);
      n_total++; if (cyc !== 5) $display("FAIL areset_latency: got %0d want 5", cyc); else n_pass++;
      n_total++; if (BNNResult !== 32'd16) $display("FAIL areset_op: got %h want 10", BNNResult); else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      bnn_func = 2'b00; start = 1;
      for (int c = 0; c < 12; c++) begin
         OpA = (c == 0) ? 32'hFFFFFFFF : (c == 6) ? 32'hF0F0F0F0 : 32'h0;
         OpB = 32'hFFFFFFFF;
         #1;
         n_total++; if (done !== (c == 5 || c == 11)) $display("FAIL b2b_done c%0d: got %b want %b", c, done, c == 5 || c == 11); else n_pass++;
         n_total++; if (stall !== !(c == 5 || c == 11)) $display("FAIL b2b_stall c%0d: got %b want %b", c, stall, !(c == 5 || c == 11)); else n_pass++;
         if (c == 5) begin
            n_total++; if (BNNResult !== 32'd32) $display("FAIL b2b_first: got %h want 20", BNNResult); else n_pass++;
         end
         if (c == 11) begin
            n_total++; if (BNNResult !== 32'd16) $display("FAIL b2b_second: got %h want 10", BNNResult); else n_pass++;
         end
         @(negedge clk);
      end
      start = 0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL b2b_idle: got %b want 0", busy); else n_pass++;
   endtask

   initial begin
      test_reset;
      @(negedge clk);
      test_raw_timing;
      @(negedge clk);
      test_funcs;
      test_flush;
      test_async_reset;
      test_back_to_back;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
